// File: rtl/trigger_capture.sv
// Acquisition front end: converts raw ADC samples to screen rows, waits for a
// slope/level crossing (or a timeout), then streams DEPTH samples into the sample RAM.
module trigger_capture #(
  parameter int DEPTH   = 160,
  parameter int SHIFT   = 7,
  parameter int OFFSET  = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        sample_en,
  input  logic [13:0] adc_data,
  input  logic [7:0]  trig_level,
  input  logic        trig_slope,
  output logic [7:0]  wr_data,
  output logic [7:0]  wr_addr,
  output logic        wr_en,
  output logic        finished,
  output logic        auto_trig
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int          TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]  LAST_ADDR = 8'(DEPTH - 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    prev_q, prev_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic          wr_en_q, wr_en_d;
  logic          finished_q, finished_d;
  logic          auto_trig_q, auto_trig_d;

  logic [13:0] shifted;
  logic [14:0] diff;
  logic [7:0]  conv;
  logic        rise_hit, fall_hit, hit;
  logic [7:0]  next_addr;

  assign shifted = adc_data >> SHIFT;

  // Saturating conversion: negative results floor at 0, large ones clamp at 255.
  always_comb begin
    diff = '0;
    conv = '0;
    if ({1'b0, shifted} >= 15'(OFFSET)) begin
      diff = {1'b0, shifted} - 15'(OFFSET);
      conv = (diff > 15'd255) ? 8'hFF : diff[7:0];
    end
  end

  assign rise_hit  = (prev_q < trig_level) && (conv >= trig_level);
  assign fall_hit  = (prev_q > trig_level) && (conv <= trig_level);
  assign hit       = trig_slope ? fall_hit : rise_hit;
  assign next_addr = 8'(wr_addr_q + 8'd1);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    tmo_d       = tmo_q;
    wr_data_d   = wr_data_q;
    wr_addr_d   = wr_addr_q;
    wr_en_d     = 1'b0;
    finished_d  = 1'b0;
    auto_trig_d = auto_trig_q;
    // Dropping enable aborts from any state; nothing new gets written.
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d     = S_ARM;
          auto_trig_d = 1'b0;
          tmo_d       = '0;
        end
        S_ARM: begin
          if (sample_en) begin
            prev_d  = conv;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (sample_en) begin
            if (hit || (tmo_q == TMO_LAST)) begin
              wr_en_d     = 1'b1;
              wr_addr_d   = 8'd0;
              wr_data_d   = conv;
              auto_trig_d = !hit;
              state_d     = (LAST_ADDR == 8'd0) ? S_DONE : S_CAPTURE;
            end else begin
              prev_d = conv;
              tmo_d  = TW'(tmo_q + 1'b1);
            end
          end
        end
        S_CAPTURE: begin
          if (sample_en) begin
            wr_en_d   = 1'b1;
            wr_addr_d = next_addr;
            wr_data_d = conv;
            if (next_addr == LAST_ADDR) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          finished_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      prev_q      <= '0;
      tmo_q       <= '0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      finished_q  <= 1'b0;
      auto_trig_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      tmo_q       <= tmo_d;
      wr_data_q   <= wr_data_d;
      wr_addr_q   <= wr_addr_d;
      wr_en_q     <= wr_en_d;
      finished_q  <= finished_d;
      auto_trig_q <= auto_trig_d;
    end
  end

  assign wr_data   = wr_data_q;
  assign wr_addr   = wr_addr_q;
  assign wr_en     = wr_en_q;
  assign finished  = finished_q;
  assign auto_trig = auto_trig_q;

endmodule

// File: doc/trigger_capture.md
Name: trigger_capture

Overview:
- Acquisition stage directly upstream of the display sequencer's sample RAM.
- Converts raw 14-bit ADC samples to 8-bit screen rows.
- Waits for a level crossing on a selectable slope, then writes one screen-width of samples into the dual-port sample RAM.
- Raises finished so the sequencer can advance to line drawing. Includes an auto-trigger timeout so the screen still refreshes when the input is flat.

Parameters:
- DEPTH, 160, number of samples captured per frame (RAM addresses 0..DEPTH-1, DEPTH<=256)
- SHIFT, 7, right shift applied to adc_data before offset
- OFFSET, 4, value subtracted after the shift
- TIMEOUT, 4096, sample_en pulses spent waiting for a trigger before auto-trigger

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous reset, active-high despite the name
- enable  in  1  level; high = run one capture, low = abort/idle
- sample_en  in  1  one-cycle strobe in clk domain marking a valid adc_data
- adc_data  in  14  raw ADC sample, valid when sample_en=1
- trig_level  in  8  trigger threshold in converted (screen) units
- trig_slope  in  1  0 = rising crossing, 1 = falling crossing
- wr_data  out  8  converted sample to RAM
- wr_addr  out  8  RAM write address
- wr_en  out  1  RAM write strobe, one cycle per captured sample
- finished  out  1  capture complete; held while enable stays high
- auto_trig  out  1  high if the current/last capture was timeout-triggered

Behaviour:
- Reset (async, rst_n=1): state=IDLE; wr_data=0, wr_addr=0, wr_en=0, finished=0, auto_trig=0; timeout counter=0; prev sample register=0.
- Conversion:
  - conv = (adc_data >> SHIFT), zero-extended to 9 bits, minus OFFSET.
  - Result below 0 saturates to 0; result above 255 clamps to 255.
  - Computed combinationally from adc_data; registered only into prev/wr_data.
- States:
  - IDLE: wait for enable=1, then go to ARM; clear auto_trig and the timeout counter.
  - ARM: the first sample_en loads prev<=conv, then go to WAIT_TRIG. Prevents a stale prev from causing a false trigger.
  - WAIT_TRIG: on each sample_en:
    - Rising hit: prev<trig_level && conv>=trig_level.
    - Falling hit: prev>trig_level && conv<=trig_level.
    - On a hit, or when timeout counter==TIMEOUT-1 (auto_trig<=1 in that case): write the current sample at address 0 and go to CAPTURE. A true hit on the timeout sample leaves auto_trig=0.
    - Otherwise: prev<=conv and the counter increments.
  - CAPTURE: each sample_en writes conv at the next address (1, 2, ...). The write at address DEPTH-1 moves to DONE.
  - DONE: finished=1 (registered, asserted the cycle after the last wr_en). Stay in DONE while enable=1. Return to IDLE when enable=0; finished clears on that transition.
- Write timing:
  - wr_en, wr_data and wr_addr are registered: they are valid in the cycle after the accepting sample_en edge.
  - wr_en is high for exactly one cycle.
  - Exactly DEPTH writes per capture, addresses strictly 0..DEPTH-1 in order, no wrap.
- sample_en outside ARM/WAIT_TRIG/CAPTURE is ignored.
- Abort: enable=0 in any state returns to IDLE on the next edge. No further wr_en is issued; finished=0. A write already registered in that cycle still completes.
- Trigger on the same cycle as the timeout is counted as a true trigger.
- trig_level and trig_slope are sampled every sample_en and may change between frames. Changes mid-wait take effect on the next sample.
- Consecutive sample_en on every clock must be supported: full-rate capture, no dropped samples.

Test Plan:
1. Reset mid-CAPTURE (rst_n pulse after 50 writes) -> all outputs 0 immediately. Next enable starts at ARM; a full 160-write capture follows from address 0.
2. Rising ramp, adc_data=k*128+... so conv = 0,1,2,...; trig_level=20, slope=0 -> first write addr 0 data 20, last write addr 159 data 179. finished high 1 cycle after the last wr_en; auto_trig=0.
3. Falling crossing 30->25 with trig_level=27, slope=1 -> addr 0 data 25. Same input with slope=0 -> no trigger until timeout.
4. Constant adc_data=0x0100 (conv=0, saturated from 2-4) with TIMEOUT=16 -> 16th waiting sample written at addr 0, auto_trig=1, 160 writes of 0.
5. Drop enable after 80 writes -> no wr_en after that, finished stays 0. Re-enable -> new capture from addr 0 after an ARM sample.
6. sample_en high every cycle, sine input crossing level -> 160 consecutive wr_en pulses, no gaps. finished held until enable falls, then cleared next cycle.
